// File: rtl/ex_stage.sv
// Execute stage: captures the decoded bundle on Controller_kick_up, runs ALU/branch/address ops, pulses EX_kick_up.
// Optional macro EX_SHIFT_FAST_EN selects a single-cycle barrel shifter instead of the 1-bit/cycle iterative shifter.
module ex_stage #(
    parameter int unsigned WIDTH                 = 32,
    parameter logic [1:0]  ALU_ARITHMETIC        = 2'd0,
    parameter logic [1:0]  ALU_CONDITIONAL_JMP   = 2'd1,
    parameter logic [1:0]  ALU_UNCONDITIONAL_JMP = 2'd2,
    parameter logic [1:0]  ALU_MEMORY            = 2'd3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Controller_kick_up,
    input  logic [1:0]       Controller_aluop,
    input  logic             Controller_alusrc,
    input  logic [WIDTH-1:0] imme,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] pc,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    output logic [WIDTH-1:0] alu_result,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] store_data,
    output logic             EX_kick_up,
    output logic             ex_busy,
    output logic             ex_overrun
);

    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t state;

    logic [1:0]       op_q;
    logic             src_q;
    logic [WIDTH-1:0] imme_q;
    logic [WIDTH-1:0] rs1_q;
    logic [WIDTH-1:0] rs2_q;
    logic [WIDTH-1:0] pc_q;
    logic [2:0]       f3_q;
    logic             f7_q;
    logic [WIDTH-1:0] sh_q;
    logic [SHW-1:0]   cnt_q;

    logic [WIDTH-1:0] opb_c;
    logic [SHW-1:0]   shamt_c;
    logic [WIDTH-1:0] res_c;
    logic             taken_c;
    logic             is_shift_c;
    logic             iter_c;
    logic [WIDTH-1:0] target_c;
    logic [WIDTH-1:0] sh_next_c;

    assign opb_c    = src_q ? imme_q : rs2_q;
    assign shamt_c  = opb_c[SHW-1:0];
    assign target_c = pc_q + imme_q;

    // Result and branch decision from the latched bundle
    always_comb begin
        res_c      = '0;
        taken_c    = 1'b0;
        is_shift_c = 1'b0;
        case (op_q)
            ALU_ARITHMETIC: begin
                case (f3_q)
                    3'b000: res_c = (f7_q && !src_q) ? rs1_q - opb_c : rs1_q + opb_c;
                    3'b001: begin
                        res_c      = rs1_q << shamt_c;
                        is_shift_c = 1'b1;
                    end
                    3'b010: res_c = WIDTH'($signed(rs1_q) < $signed(opb_c));
                    3'b011: res_c = WIDTH'(rs1_q < opb_c);
                    3'b100: res_c = rs1_q ^ opb_c;
                    3'b101: begin
                        res_c      = f7_q ? $unsigned($signed(rs1_q) >>> shamt_c) : rs1_q >> shamt_c;
                        is_shift_c = 1'b1;
                    end
                    3'b110: res_c = rs1_q | opb_c;
                    default: res_c = rs1_q & opb_c;
                endcase
            end
            ALU_CONDITIONAL_JMP: begin
                case (f3_q)
                    3'b000: taken_c = (rs1_q == rs2_q);
                    3'b001: taken_c = (rs1_q != rs2_q);
                    3'b100: taken_c = ($signed(rs1_q) < $signed(rs2_q));
                    3'b101: taken_c = ($signed(rs1_q) >= $signed(rs2_q));
                    3'b110: taken_c = (rs1_q < rs2_q);
                    3'b111: taken_c = (rs1_q >= rs2_q);
                    default: taken_c = 1'b0;
                endcase
            end
            ALU_UNCONDITIONAL_JMP: begin
                res_c   = pc_q + WIDTH'(4);
                taken_c = 1'b1;
            end
            ALU_MEMORY: res_c = rs1_q + imme_q;
            default: res_c = '0;
        endcase
    end

`ifdef EX_SHIFT_FAST_EN
    assign iter_c = 1'b0;
`else
    assign iter_c = is_shift_c && (shamt_c != '0);
`endif

    // One-bit step of the iterative shifter; direction and fill come from the latched funct fields
    always_comb begin
        sh_next_c = sh_q;
        if (f3_q == 3'b001)
            sh_next_c = {sh_q[WIDTH-2:0], 1'b0};
        else
            sh_next_c = {f7_q & sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= '0;
            src_q         <= 1'b0;
            imme_q        <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            pc_q          <= '0;
            f3_q          <= '0;
            f7_q          <= 1'b0;
            sh_q          <= '0;
            cnt_q         <= '0;
            alu_result    <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            store_data    <= '0;
            EX_kick_up    <= 1'b0;
            ex_busy       <= 1'b0;
            ex_overrun    <= 1'b0;
        end else begin
            EX_kick_up <= 1'b0;
            if (Controller_kick_up && state != IDLE)
                ex_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (Controller_kick_up) begin
                        op_q    <= Controller_aluop;
                        src_q   <= Controller_alusrc;
                        imme_q  <= imme;
                        rs1_q   <= rs1_data;
                        rs2_q   <= rs2_data;
                        pc_q    <= pc;
                        f3_q    <= funct3;
                        f7_q    <= funct7_5;
                        state   <= EXEC;
                        ex_busy <= 1'b1;
                    end
                end
                EXEC: begin
                    if (iter_c) begin
                        sh_q  <= rs1_q;
                        cnt_q <= shamt_c;
                        state <= SHIFT;
                    end else begin
                        alu_result    <= res_c;
                        branch_taken  <= taken_c;
                        branch_target <= target_c;
                        store_data    <= rs2_q;
                        EX_kick_up    <= 1'b1;
                        ex_busy       <= 1'b0;
                        state         <= IDLE;
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_next_c;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        alu_result    <= sh_next_c;
                        branch_taken  <= 1'b0;
                        branch_target <= target_c;
                        store_data    <= rs2_q;
                        EX_kick_up    <= 1'b1;
                        ex_busy       <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    ex_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed literal cases plus random traffic against a countdown reference model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Controller_kick_up = 1'b0;
    logic [1:0]  Controller_aluop = 2'd0;
    logic        Controller_alusrc = 1'b0;
    logic [31:0] imme = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] pc = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_5 = 1'b0;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] store_data;
    logic        EX_kick_up;
    logic        ex_busy;
    logic        ex_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    ex_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .Controller_kick_up(Controller_kick_up), .Controller_aluop(Controller_aluop),
        .Controller_alusrc(Controller_alusrc), .imme(imme), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .pc(pc), .funct3(funct3), .funct7_5(funct7_5),
        .alu_result(alu_result), .branch_taken(branch_taken), .branch_target(branch_target),
        .store_data(store_data), .EX_kick_up(EX_kick_up), .ex_busy(ex_busy),
        .ex_overrun(ex_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference: what a single instruction produces and how many clock edges it takes after acceptance
    task automatic ref_op(input logic [1:0] op, input logic src, input logic [31:0] im,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                          input logic [2:0] f3, input logic f7,
                          output logic [31:0] res, output logic tk, output int edges);
        logic [31:0] opb;
        int sh;
        opb   = src ? im : b;
        sh    = int'(opb[4:0]);
        res   = 32'd0;
        tk    = 1'b0;
        edges = 1;
        case (op)
            2'd0: begin
                case (f3)
                    3'd0: res = (f7 && !src) ? a - opb : a + opb;
                    3'd1: res = a << sh;
                    3'd2: res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < opb) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ opb;
                    3'd5: res = f7 ? $unsigned($signed(a) >>> sh) : a >> sh;
                    3'd6: res = a | opb;
                    default: res = a & opb;
                endcase
`ifndef EX_SHIFT_FAST_EN
                if ((f3 == 3'd1 || f3 == 3'd5) && sh != 0) edges = 1 + sh;
`endif
            end
            2'd1: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
            end
            2'd2: begin
                res = p + 32'd4;
                tk  = 1'b1;
            end
            default: res = a + im;
        endcase
    endtask

    logic [31:0] exp_res = '0, exp_tgt = '0, exp_st = '0;
    logic        exp_tk = 1'b0, exp_kick = 1'b0, exp_busy = 1'b0, exp_ovr = 1'b0;
    logic [31:0] p_res, p_tgt, p_st;
    logic        p_tk;
    int          pend = 0;

    // Model: one instruction in flight, counting down edges to its completion
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_res = '0; exp_tgt = '0; exp_st = '0;
            exp_tk = 1'b0; exp_kick = 1'b0; exp_busy = 1'b0; exp_ovr = 1'b0;
            pend = 0;
        end else begin
            exp_kick = 1'b0;
            if (pend > 0) begin
                if (Controller_kick_up) exp_ovr = 1'b1;
                pend--;
                if (pend == 0) begin
                    exp_res = p_res; exp_tk = p_tk; exp_tgt = p_tgt; exp_st = p_st;
                    exp_kick = 1'b1;
                end
            end else if (Controller_kick_up) begin
                ref_op(Controller_aluop, Controller_alusrc, imme, rs1_data, rs2_data, pc,
                       funct3, funct7_5, p_res, p_tk, pend);
                p_tgt = pc + imme;
                p_st  = rs2_data;
            end
            exp_busy = (pend > 0);
        end
    end

    // Per-cycle comparison against the model, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        chk("m_alu_result", alu_result, exp_res);
        chk("m_branch_taken", 32'(branch_taken), 32'(exp_tk));
        chk("m_branch_target", branch_target, exp_tgt);
        chk("m_store_data", store_data, exp_st);
        chk("m_EX_kick_up", 32'(EX_kick_up), 32'(exp_kick));
        chk("m_ex_busy", 32'(ex_busy), 32'(exp_busy));
        chk("m_ex_overrun", 32'(ex_overrun), 32'(exp_ovr));
    end

    task automatic drive(input logic [1:0] op, input logic src, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                         input logic [2:0] f3, input logic f7);
        Controller_aluop = op; Controller_alusrc = src; imme = im;
        rs1_data = a; rs2_data = b; pc = p; funct3 = f3; funct7_5 = f7;
    endtask

    // Kick one op (optionally a second kick the next cycle) and check literal results and latency
    task automatic do_op(input string nm, input bit dbl,
                         input logic [1:0] op, input logic src, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                         input logic [2:0] f3, input logic f7,
                         input logic [31:0] e_res, input logic e_tk, input logic [31:0] e_tgt,
                         input logic [31:0] e_st, input int e_lat);
        int n;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        drive(op, src, im, a, b, p, f3, f7);
        Controller_kick_up = 1'b1;
        @(negedge clk);
        if (dbl) rs1_data = ~a;
        else Controller_kick_up = 1'b0;
        n = 1; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && n < 100) begin
            if (EX_kick_up) seen = 1'b1;
            else begin
                if (!ex_busy) busy_ok = 1'b0;
                @(negedge clk);
                Controller_kick_up = 1'b0;
                n++;
            end
        end
        chk({nm, "_latency"}, 32'(n), 32'(e_lat));
        chk({nm, "_busy_during"}, 32'(busy_ok), 32'd1);
        chk({nm, "_alu_result"}, alu_result, e_res);
        chk({nm, "_branch_taken"}, 32'(branch_taken), 32'(e_tk));
        chk({nm, "_branch_target"}, branch_target, e_tgt);
        chk({nm, "_store_data"}, store_data, e_st);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: rnd_word = 32'h8000_0000;
            1: rnd_word = 32'hFFFF_FFFF;
            2: rnd_word = 32'($urandom_range(0, 40));
            default: rnd_word = $urandom;
        endcase
    endfunction

`ifdef EX_SHIFT_FAST_EN
    localparam int SRA_LAT = 2;
    localparam int SLL_LAT = 2;
`else
    localparam int SRA_LAT = 6;
    localparam int SLL_LAT = 12;
`endif

    initial begin
        int pulses;
        repeat (2) @(negedge clk);
        chk("rst_alu_result", alu_result, 32'd0);
        chk("rst_kick", 32'(EX_kick_up), 32'd0);
        chk("rst_busy", 32'(ex_busy), 32'd0);
        reset = 1'b0;

        do_op("add",  0, 2'd0, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0, 3'b000, 1'b0,
              32'd12, 1'b0, 32'h0, 32'd7, 2);
        do_op("sub",  0, 2'd0, 1'b0, 32'h20, 32'd3, 32'd5, 32'h10, 3'b000, 1'b1,
              32'hFFFF_FFFE, 1'b0, 32'h30, 32'd5, 2);
        do_op("addi", 0, 2'd0, 1'b1, 32'd5, 32'd3, 32'd5, 32'h10, 3'b000, 1'b1,
              32'd8, 1'b0, 32'h15, 32'd5, 2);
        do_op("srai", 0, 2'd0, 1'b1, 32'd4, 32'h8000_0000, 32'd0, 32'h0, 3'b101, 1'b1,
              32'hF800_0000, 1'b0, 32'h4, 32'd0, SRA_LAT);
        do_op("blt",  0, 2'd1, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 32'h100, 3'b100, 1'b0,
              32'd0, 1'b1, 32'hF0, 32'd1, 2);
        do_op("bltu", 0, 2'd1, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 32'h100, 3'b110, 1'b0,
              32'd0, 1'b0, 32'hF0, 32'd1, 2);
        do_op("jal",  0, 2'd2, 1'b1, 32'd8, 32'd0, 32'd0, 32'h40, 3'b000, 1'b0,
              32'h44, 1'b1, 32'h48, 32'd0, 2);
        do_op("store", 0, 2'd3, 1'b1, 32'hFFFF_FFFC, 32'h1000, 32'hAB, 32'h0, 3'b010, 1'b0,
              32'hFFC, 1'b0, 32'hFFFF_FFFC, 32'hAB, 2);
        chk("no_overrun_yet", 32'(ex_overrun), 32'd0);
        do_op("sll_ovr", 1, 2'd0, 1'b1, 32'd10, 32'd3, 32'd0, 32'h0, 3'b001, 1'b0,
              32'hC00, 1'b0, 32'hA, 32'd0, SLL_LAT);
        chk("overrun_set", 32'(ex_overrun), 32'd1);

        // Reset in the middle of a long shift
        @(negedge clk);
        drive(2'd0, 1'b1, 32'd20, 32'hFFFF_FFFF, 32'h55, 32'h200, 3'b101, 1'b0);
        Controller_kick_up = 1'b1;
        @(negedge clk);
        Controller_kick_up = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_alu_result", alu_result, 32'd0);
        chk("midrst_taken", 32'(branch_taken), 32'd0);
        chk("midrst_target", branch_target, 32'd0);
        chk("midrst_store", store_data, 32'd0);
        chk("midrst_busy", 32'(ex_busy), 32'd0);
        chk("midrst_overrun", 32'(ex_overrun), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (EX_kick_up) pulses++;
        end
        chk("midrst_no_pulse", 32'(pulses), 32'd0);

        // Random traffic, including kicks while busy and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 499) == 0) reset = 1'b1;
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd_word(), rnd_word(),
                  rnd_word(), rnd_word(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            Controller_kick_up = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        Controller_kick_up = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
